result_packer: RTL and testbench

RESULT_PACKER -- requirements
Module: result_packer

---
 rtl/result_packer.sv | 95 +++++++++
 tb/tb_result_packer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_packer.sv
// rtl/result_packer.sv - gathers systolic-array result rows into N x N frames
// and hands them to the DMA through a two-slot ping-pong buffer.
module result_packer #(
  parameter int RES_WIDTH = 16,
  parameter int N         = 3
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_flush,
  input  logic                       i_res_valid,
  input  logic [N*RES_WIDTH-1:0]     i_res_row,
  output logic                       o_res_ready,
  output logic                       m_axis_valid,
  output logic [N*N*RES_WIDTH-1:0]   m_axis_data,
  input  logic                       m_axis_ready,
  output logic [15:0]                o_frames_out
);

  localparam int ROW_W   = N * RES_WIDTH;
  localparam int FRAME_W = N * ROW_W;
  localparam int CNT_W   = (N > 1) ? $clog2(N) : 1;

  logic [FRAME_W-1:0] slot_q [2];
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   row_q, row_d;
  logic [1:0]         count_q, count_d;
  logic [15:0]        frames_q, frames_d;

  logic accept, deliver, commit;

  assign o_res_ready  = (count_q != 2'd2);
  assign m_axis_valid = (count_q != 2'd0);
  assign m_axis_data  = slot_q[rd_ptr_q];
  assign o_frames_out = frames_q;

  assign accept  = i_res_valid && o_res_ready;
  assign deliver = m_axis_valid && m_axis_ready;
  assign commit  = accept && (row_q == CNT_W'(N - 1));

  always_comb begin
    row_d    = row_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    frames_d = frames_q;
    if (i_flush) begin
      // Flush wins over any handshake in the same cycle; the delivery count is kept.
      row_d    = '0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (accept) begin
        row_d = commit ? '0 : row_q + CNT_W'(1);
      end
      if (commit) begin
        wr_ptr_d = ~wr_ptr_q;
      end
      if (deliver) begin
        rd_ptr_d = ~rd_ptr_q;
        frames_d = frames_q + 16'd1;
      end
      count_d = count_q + {1'b0, commit} - {1'b0, deliver};
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      row_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      frames_q <= 16'd0;
    end else begin
      row_q    <= row_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      frames_q <= frames_d;
    end
  end

  // Slot payload carries no reset; only count/pointers decide what is valid.
  always_ff @(posedge i_clk) begin
    if (accept && !i_flush) begin
      for (int r = 0; r < N; r++) begin
        if (row_q == CNT_W'(r)) begin
          slot_q[wr_ptr_q][r*ROW_W +: ROW_W] <= i_res_row;
        end
      end
    end
  end

endmodule

// File: tb/tb_result_packer.sv
// tb/tb_result_packer.sv - scoreboard bench for result_packer with a
// frame-queue reference model.
module tb_result_packer;

  localparam int RW      = 16;
  localparam int N       = 3;
  localparam int ROW_W   = N * RW;
  localparam int FRAME_W = N * ROW_W;

  logic               i_clk;
  logic               i_rst;
  logic               i_flush;
  logic               i_res_valid;
  logic [ROW_W-1:0]   i_res_row;
  logic               o_res_ready;
  logic               m_axis_valid;
  logic [FRAME_W-1:0] m_axis_data;
  logic               m_axis_ready;
  logic [15:0]        o_frames_out;

  result_packer #(.RES_WIDTH(RW), .N(N)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_flush      (i_flush),
    .i_res_valid  (i_res_valid),
    .i_res_row    (i_res_row),
    .o_res_ready  (o_res_ready),
    .m_axis_valid (m_axis_valid),
    .m_axis_data  (m_axis_data),
    .m_axis_ready (m_axis_ready),
    .o_frames_out (o_frames_out)
  );

  int errors = 0;
  int checks = 0;

  logic [FRAME_W-1:0] exp_q[$];
  int                 mcount = 0;
  int                 mrow   = 0;
  logic [FRAME_W-1:0] mpart  = '0;
  logic [15:0]        mframes = 16'd0;

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic check(input string name, input logic [FRAME_W-1:0] act, input logic [FRAME_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=handshake t=%0t", name, $time);
  endtask

  function automatic logic [ROW_W-1:0] row_val(input int k);
    logic [ROW_W-1:0] r;
    for (int c = 0; c < N; c++) r[c*RW +: RW] = RW'(N*k + c + 1);
    return r;
  endfunction

  function automatic logic [FRAME_W-1:0] frame_val(input int base);
    logic [FRAME_W-1:0] f;
    for (int r = 0; r < N; r++) f[r*ROW_W +: ROW_W] = row_val(base + r);
    return f;
  endfunction

  // Reference model: a partial frame being built and a FIFO of at most two finished frames.
  initial begin
    bit acc, del;
    forever begin
      @(posedge i_clk);
      if (i_rst) begin
        mcount = 0; mrow = 0; mpart = '0; mframes = 16'd0; exp_q.delete();
      end else if (i_flush) begin
        mcount = 0; mrow = 0; mpart = '0; exp_q.delete();
      end else begin
        acc = i_res_valid && (mcount != 2);
        del = (mcount != 0) && m_axis_ready;
        if (acc) begin
          mpart = mpart | (FRAME_W'(i_res_row) << (mrow * ROW_W));
          if (mrow == N - 1) begin
            exp_q.push_back(mpart);
            mpart = '0;
            mrow = 0;
            mcount++;
          end else begin
            mrow++;
          end
        end
        if (del) begin
          mcount--;
          mframes = mframes + 16'd1;
        end
      end
    end
  end

  // Monitor: compares DUT outputs against the model each cycle, popping on delivery.
  initial begin
    forever begin
      @(negedge i_clk);
      #2;
      check("res_ready", FRAME_W'(o_res_ready), FRAME_W'(mcount != 2));
      check("axis_valid", FRAME_W'(m_axis_valid), FRAME_W'(mcount != 0));
      check("frames_out", FRAME_W'(o_frames_out), FRAME_W'(mframes));
      if (mcount != 0) begin
        if (exp_q.size() == 0) begin
          timeout("scoreboard_empty");
        end else begin
          check("axis_data", m_axis_data, exp_q[0]);
          if (m_axis_ready && !i_flush && !i_rst) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic drive(input bit v, input logic [ROW_W-1:0] row, input bit rdy, input bit fl);
    @(negedge i_clk);
    i_res_valid  = v;
    i_res_row    = row;
    m_axis_ready = rdy;
    i_flush      = fl;
  endtask

  task automatic feed_rows(input int n, input bit rdy, input int base);
    int k = 0;
    int budget = 40;
    while (k < n && budget > 0) begin
      drive(1'b1, row_val(base + k), rdy, 1'b0);
      #1;
      if (o_res_ready) k++;
      budget--;
    end
    if (k < n) timeout("feed_rows");
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) drive(1'b0, ROW_W'($urandom), rdy, 1'b0);
  endtask

  initial begin
    logic [ROW_W-1:0] pend[$];
    int acc_cnt;
    int budget;
    logic [FRAME_W-1:0] basic_exp;

    i_rst = 1'b1; i_flush = 1'b0; i_res_valid = 1'b0; i_res_row = '0; m_axis_ready = 1'b0;
    @(negedge i_clk);
    #1;
    check("rst_valid", FRAME_W'(m_axis_valid), '0);
    check("rst_ready", FRAME_W'(o_res_ready), FRAME_W'(1));
    check("rst_frames", FRAME_W'(o_frames_out), '0);
    @(negedge i_clk);
    i_rst = 1'b0;

    // Basic frame
    feed_rows(3, 1'b1, 0);
    drive(1'b0, '0, 1'b1, 1'b0);
    #1;
    basic_exp = 144'h0009_0008_0007_0006_0005_0004_0003_0002_0001;
    check("basic_valid", FRAME_W'(m_axis_valid), FRAME_W'(1));
    check("basic_data", m_axis_data, basic_exp);
    drive(1'b0, '0, 1'b1, 1'b0);
    #1;
    check("basic_frames", FRAME_W'(o_frames_out), FRAME_W'(1));

    // Backpressure: 9 rows offered with the DMA stalled
    for (int k = 0; k < 9; k++) pend.push_back(row_val(20 + k));
    acc_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      drive(1'b1, pend[0], 1'b0, 1'b0);
      #1;
      if (o_res_ready) begin void'(pend.pop_front()); acc_cnt++; end
    end
    check("bp_accepted", FRAME_W'(acc_cnt), FRAME_W'(6));
    check("bp_ready_low", FRAME_W'(o_res_ready), '0);
    check("bp_data_hold", m_axis_data, frame_val(20));
    budget = 20;
    while (pend.size() > 0 && budget > 0) begin
      drive(1'b1, pend[0], 1'b1, 1'b0);
      #1;
      if (o_res_ready) void'(pend.pop_front());
      budget--;
    end
    if (pend.size() > 0) timeout("bp_drain");
    idle(3, 1'b1);
    #1;
    check("bp_frames", FRAME_W'(o_frames_out), FRAME_W'(4));

    // Commit and delivery in the same cycle
    feed_rows(3, 1'b0, 100);
    feed_rows(2, 1'b0, 103);
    drive(1'b1, row_val(105), 1'b1, 1'b0);
    #1;
    check("sim_ready", FRAME_W'(o_res_ready), FRAME_W'(1));
    drive(1'b0, '0, 1'b0, 1'b0);
    #1;
    check("sim_valid", FRAME_W'(m_axis_valid), FRAME_W'(1));
    check("sim_data", m_axis_data, frame_val(103));
    check("sim_frames", FRAME_W'(o_frames_out), FRAME_W'(5));
    idle(2, 1'b1);

    // Flush with one full frame and a partial frame pending
    feed_rows(5, 1'b0, 200);
    drive(1'b0, '0, 1'b1, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b0);
    #1;
    check("flush_valid", FRAME_W'(m_axis_valid), '0);
    check("flush_frames", FRAME_W'(o_frames_out), FRAME_W'(6));
    feed_rows(3, 1'b0, 210);
    drive(1'b0, '0, 1'b0, 1'b0);
    #1;
    check("flush_data", m_axis_data, frame_val(210));
    idle(2, 1'b1);

    // Asynchronous reset between clock edges
    feed_rows(5, 1'b0, 300);
    drive(1'b0, '0, 1'b0, 1'b0);
    #3;
    i_rst = 1'b1;
    #1;
    check("arst_valid", FRAME_W'(m_axis_valid), '0);
    check("arst_ready", FRAME_W'(o_res_ready), FRAME_W'(1));
    check("arst_frames", FRAME_W'(o_frames_out), '0);
    @(negedge i_clk);
    i_rst = 1'b0;
    feed_rows(3, 1'b0, 310);
    drive(1'b0, '0, 1'b0, 1'b0);
    #1;
    check("arst_data", m_axis_data, frame_val(310));
    idle(2, 1'b1);

    // Frame counter wrap
    @(negedge i_clk);
    force dut.frames_q = 16'hFFFF;
    mframes = 16'hFFFF;
    #1;
    release dut.frames_q;
    feed_rows(3, 1'b1, 400);
    idle(2, 1'b1);
    #1;
    check("wrap_frames", FRAME_W'(o_frames_out), '0);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, ROW_W'({$urandom, $urandom}),
            $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0);
    end
    idle(4, 1'b1);
    #3;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
